// File: rtl/gray_conv_arbiter_if.sv
// rtl/gray_conv_arbiter_if.sv - requester/consumer bundle for the shared Gray converter
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_bin;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_bin;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_gray;
  logic             out_id;
  logic             out_ready;
  logic [CNT_W-1:0] conv_count;

  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    input  req0_ready, req1_ready, out_valid, out_gray, out_id, conv_count
  );

  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    output req0_ready, req1_ready, out_valid, out_gray, out_id, conv_count
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester round-robin front end to one binary-to-Gray converter
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic             out_id_q, out_id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] conv_count_q, conv_count_d;

  logic             slot_free;
  logic             grant;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] sel_bin;

  // Round-robin arbitration; a lone requester wins outright, a tie goes to the one not served last
  always_comb begin
    slot_free = (state_q == EMPTY) | bus.out_ready;
    if (bus.req0_valid & bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    accept  = slot_free & (bus.req0_valid | bus.req1_valid);
    deliver = (state_q == FULL) & bus.out_ready;
    sel_bin = grant ? bus.req1_bin : bus.req0_bin;
  end

  // Control state register: EMPTY/FULL mirrors out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill on accept, empty only on a drain that is not refilled the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (deliver & ~accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Datapath next values: convert the winner's operand, remember who won, count deliveries
  always_comb begin
    out_gray_d   = out_gray_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    conv_count_d = conv_count_q + CNT_W'(deliver);
    if (accept) begin
      out_gray_d   = sel_bin ^ (sel_bin >> 1);
      out_id_d     = grant;
      last_grant_d = grant;
    end
  end

  // Datapath registers; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      out_gray_q   <= '0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      conv_count_q <= '0;
    end else begin
      out_gray_q   <= out_gray_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
      conv_count_q <= conv_count_d;
    end
  end

  // Outputs: readies are combinational from the grant, result fields come straight from flops
  always_comb begin
    bus.req0_ready = slot_free & bus.req0_valid & ~grant;
    bus.req1_ready = slot_free & bus.req1_valid & grant;
    bus.out_valid  = (state_q == FULL);
    bus.out_gray   = out_gray_q;
    bus.out_id     = out_id_q;
    bus.conv_count = conv_count_q;
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed and randomized checks of gray_conv_arbiter against a behavioural model
module tb_gray_conv_arbiter;

  logic clk;
  logic rst;

  gray_conv_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus ();
  gray_conv_arbiter_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  gray_conv_arbiter #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gray_conv_arbiter #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.req0_valid = bus.req0_valid;
  assign bus2.req0_bin   = bus.req0_bin;
  assign bus2.req1_valid = bus.req1_valid;
  assign bus2.req1_bin   = bus.req1_bin;
  assign bus2.out_ready  = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       m_valid;
  logic [3:0] m_gray;
  logic       m_id;
  logic       m_last;
  int         m_cnt;
  int         m_cnt2;
  logic       acc0;
  logic       acc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_gray  = 4'd0;
    m_id    = 1'b0;
    m_last  = 1'b1;
    m_cnt   = 0;
    m_cnt2  = 0;
  endtask

  task automatic step();
    logic free;
    logic win;
    logic e0;
    logic e1;
    logic [3:0] b;
    #1;
    free = !m_valid || bus.out_ready;
    if (bus.req0_valid && bus.req1_valid) win = !m_last;
    else win = bus.req1_valid;
    e0 = free && bus.req0_valid && !win;
    e1 = free && bus.req1_valid && win;
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_gray", 32'(bus.out_gray), 32'(m_gray));
    chk("out_id", 32'(bus.out_id), 32'(m_id));
    chk("conv_count", 32'(bus.conv_count), 32'(m_cnt));
    chk("conv_count_w2", 32'(bus2.conv_count), 32'(m_cnt2));
    acc0 = e0;
    acc1 = e1;
    if (rst) begin
      model_reset();
    end else begin
      if (m_valid && bus.out_ready) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_cnt2 = (m_cnt2 + 1) % 4;
      end
      if (e0 || e1) begin
        b       = win ? bus.req1_bin : bus.req0_bin;
        m_gray  = to_gray(b);
        m_id    = win;
        m_last  = win;
        m_valid = 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int gt[10];
    int c2[5];
    gt = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};
    c2 = '{1, 2, 3, 0, 1};

    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_bin   = 4'd0;
    bus.req1_valid = 1'b0;
    bus.req1_bin   = 4'd0;
    bus.out_ready  = 1'b0;
    acc0           = 1'b0;
    acc1           = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_gray", 32'(bus.out_gray), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);
    chk("rst_count", 32'(bus.conv_count), 32'd0);

    // single conversion from requester 0
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_bin = 4'd5; bus.out_ready = 1'b1;
    #1 chk("t1_ready", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_gray", 32'(bus.out_gray), 32'd7);
    chk("t1_id", 32'(bus.out_id), 32'd0);
    step();
    chk("t1_count", 32'(bus.conv_count), 32'd1);

    // both held from reset alternate
    rst = 1'b1; step(); rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_bin = 4'd3;
    bus.req1_valid = 1'b1; bus.req1_bin = 4'd9;
    step();
    chk("t2_gray_a", 32'(bus.out_gray), 32'd2);  chk("t2_id_a", 32'(bus.out_id), 32'd0);
    step();
    chk("t2_gray_b", 32'(bus.out_gray), 32'd13); chk("t2_id_b", 32'(bus.out_id), 32'd1);
    step();
    chk("t2_gray_c", 32'(bus.out_gray), 32'd2);  chk("t2_id_c", 32'(bus.out_id), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();

    // back-to-back sweep from requester 1
    bus.req1_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      bus.req1_bin = 4'(b);
      step();
      chk("t3_gray", 32'(bus.out_gray), 32'(gt[b]));
      chk("t3_id", 32'(bus.out_id), 32'd1);
    end
    bus.req1_valid = 1'b0;
    step();

    // backpressure hold then round-robin release
    bus.req0_valid = 1'b1; bus.req0_bin = 4'd15;
    step();
    chk("t4_fill", 32'(bus.out_gray), 32'd8);
    bus.out_ready = 1'b0;
    bus.req0_bin = 4'd2;
    bus.req1_valid = 1'b1; bus.req1_bin = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_gray", 32'(bus.out_gray), 32'd8);
      chk("t4_hold_r0", 32'(bus.req0_ready), 32'd0);
      chk("t4_hold_r1", 32'(bus.req1_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1 chk("t4_rr", 32'(bus.req1_ready), 32'd1);
    step();
    chk("t4_gray", 32'(bus.out_gray), 32'd5);
    bus.req1_valid = 1'b0;
    step();
    chk("t4_gray2", 32'(bus.out_gray), 32'd3);
    bus.req0_valid = 1'b0;
    step();

    // reset while full and stalled
    bus.req0_valid = 1'b1; bus.req0_bin = 4'd5;
    step();
    bus.req0_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_gray", 32'(bus.out_gray), 32'd0);
    chk("t5_count", 32'(bus.conv_count), 32'd0);
    bus.out_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_bin = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_bin = 4'd4;
    #1;
    chk("t5_first0", 32'(bus.req0_ready), 32'd1);
    chk("t5_first1", 32'(bus.req1_ready), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    step();
    bus.req1_valid = 1'b0;
    step();

    // narrow counter wraps
    rst = 1'b1; step(); rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_bin = 4'(($urandom));
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_count2", 32'(bus2.conv_count), 32'(c2[k]));
    end
    bus.req0_valid = 1'b0;
    step();

    // randomized traffic honouring the hold-until-ready rule
    for (int n = 0; n < 600; n++) begin
      if (!(bus.req0_valid && !acc0)) begin
        bus.req0_valid = ($urandom % 10) < 6;
        bus.req0_bin   = 4'($urandom);
      end
      if (!(bus.req1_valid && !acc1)) begin
        bus.req1_valid = ($urandom % 10) < 6;
        bus.req1_bin   = 4'($urandom);
      end
      bus.out_ready = ($urandom % 10) < 7;
      rst = ($urandom % 60) == 0;
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
